onchip_memory_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 32-bit on-chip RAM (16384 words, 1-cycle read latency) between the Nios data master and the audio filter sample engine. It presents an Avalon-MM slave with waitrequest/readdatavalid to each requester. It drives the RAM's chipselect/write/address/byteenable/clken port directly. Arbitration is round-robin at single-word granularity, with one RAM access issued per cycle.

---
 rtl/onchip_memory_arbiter.sv | 105 ++++++++++
 tb/tb_onchip_memory_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM
// requesters, one word access per cycle, with a one-stage read-return pipeline.
module onchip_memory_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_m0_address,
   input  logic [BE_W-1:0]   i_m0_byteenable,
   input  logic              i_m0_read,
   input  logic              i_m0_write,
   input  logic [DATA_W-1:0] i_m0_writedata,
   output logic              o_m0_waitrequest,
   output logic [DATA_W-1:0] o_m0_readdata,
   output logic              o_m0_readdatavalid,
   input  logic [ADDR_W-1:0] i_m1_address,
   input  logic [BE_W-1:0]   i_m1_byteenable,
   input  logic              i_m1_read,
   input  logic              i_m1_write,
   input  logic [DATA_W-1:0] i_m1_writedata,
   output logic              o_m1_waitrequest,
   output logic [DATA_W-1:0] o_m1_readdata,
   output logic              o_m1_readdatavalid,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [BE_W-1:0]   o_mem_byteenable,
   output logic              o_mem_chipselect,
   output logic              o_mem_write,
   output logic [DATA_W-1:0] o_mem_writedata,
   output logic              o_mem_clken,
   input  logic [DATA_W-1:0] i_mem_readdata
);

   logic              r_last;
   logic              r_rdValid;
   logic              r_rdId;

   logic              w_m0Req;
   logic              w_m1Req;
   logic              w_grant0;
   logic              w_grant1;
   logic              w_grantAny;
   logic              w_selWrite;
   logic [ADDR_W-1:0] w_selAddr;
   logic [DATA_W-1:0] w_selData;
   logic [BE_W-1:0]   w_selBe;

   assign w_m0Req    = i_m0_read | i_m0_write;
   assign w_m1Req    = i_m1_read | i_m1_write;
   // Under contention the requester that was not served last wins.
   assign w_grant0   = ~i_reset & w_m0Req & (~w_m1Req | r_last);
   assign w_grant1   = ~i_reset & w_m1Req & (~w_m0Req | ~r_last);
   assign w_grantAny = w_grant0 | w_grant1;

   // A command with read and write both high is carried out as a write.
   always_comb begin
      w_selWrite = 1'b0;
      w_selAddr  = '0;
      w_selData  = '0;
      w_selBe    = '1;
      if (w_grant0) begin
         w_selWrite = i_m0_write;
         w_selAddr  = i_m0_address;
         w_selData  = i_m0_writedata;
         w_selBe    = i_m0_write ? i_m0_byteenable : '1;
      end else if (w_grant1) begin
         w_selWrite = i_m1_write;
         w_selAddr  = i_m1_address;
         w_selData  = i_m1_writedata;
         w_selBe    = i_m1_write ? i_m1_byteenable : '1;
      end
   end

   assign o_m0_waitrequest = ~w_grant0;
   assign o_m1_waitrequest = ~w_grant1;

   assign o_mem_chipselect = w_grantAny;
   assign o_mem_write      = w_selWrite;
   assign o_mem_address    = w_selAddr;
   assign o_mem_writedata  = w_selData;
   assign o_mem_byteenable = w_selBe;
   assign o_mem_clken      = ~i_reset;

   // Read data is broadcast; only the matching strobe qualifies it.
   assign o_m0_readdata      = i_mem_readdata;
   assign o_m1_readdata      = i_mem_readdata;
   assign o_m0_readdatavalid = ~i_reset & r_rdValid & ~r_rdId;
   assign o_m1_readdatavalid = ~i_reset & r_rdValid &  r_rdId;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last    <= 1'b1;
         r_rdValid <= 1'b0;
         r_rdId    <= 1'b0;
      end else begin
         if (w_grantAny) begin
            r_last <= w_grant1;
            r_rdId <= w_grant1;
         end
         r_rdValid <= w_grantAny & ~w_selWrite;
      end
   end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter: a behavioural RAM, per-cycle grant
// checks, and a scoreboard of expected read returns popped by a monitor.
module tb_onchip_memory_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } cmd_t;

   typedef struct {
      int                id;
      logic [DATA_W-1:0] data;
      int                cyc;
   } sbEntry_t;

   localparam cmd_t IDLE = '0;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] m0Address, m1Address;
   logic [BE_W-1:0]   m0Byteenable, m1Byteenable;
   logic              m0Read, m1Read, m0Write, m1Write;
   logic [DATA_W-1:0] m0Writedata, m1Writedata;
   logic              m0Waitrequest, m1Waitrequest;
   logic [DATA_W-1:0] m0Readdata, m1Readdata;
   logic              m0Readdatavalid, m1Readdatavalid;
   logic [ADDR_W-1:0] memAddress;
   logic [BE_W-1:0]   memByteenable;
   logic              memChipselect, memWrite, memClken;
   logic [DATA_W-1:0] memWritedata;
   logic [DATA_W-1:0] memReaddata;

   int checks      = 0;
   int passes      = 0;
   int cycleCount  = 0;
   int protoErrors = 0;
   sbEntry_t sbQ[$];

   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
      .i_clk              (clk),
      .i_reset            (reset),
      .i_m0_address       (m0Address),
      .i_m0_byteenable    (m0Byteenable),
      .i_m0_read          (m0Read),
      .i_m0_write         (m0Write),
      .i_m0_writedata     (m0Writedata),
      .o_m0_waitrequest   (m0Waitrequest),
      .o_m0_readdata      (m0Readdata),
      .o_m0_readdatavalid (m0Readdatavalid),
      .i_m1_address       (m1Address),
      .i_m1_byteenable    (m1Byteenable),
      .i_m1_read          (m1Read),
      .i_m1_write         (m1Write),
      .i_m1_writedata     (m1Writedata),
      .o_m1_waitrequest   (m1Waitrequest),
      .o_m1_readdata      (m1Readdata),
      .o_m1_readdatavalid (m1Readdatavalid),
      .o_mem_address      (memAddress),
      .o_mem_byteenable   (memByteenable),
      .o_mem_chipselect   (memChipselect),
      .o_mem_write        (memWrite),
      .o_mem_writedata    (memWritedata),
      .o_mem_clken        (memClken),
      .i_mem_readdata     (memReaddata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = '0;
      memReaddata = '0;
   end

   // Single-port RAM with one-cycle read latency and byte-lane writes.
   always @(posedge clk) begin
      if (memClken && memChipselect) begin
         if (memWrite) begin
            for (int b = 0; b < BE_W; b++)
               if (memByteenable[b]) ram[memAddress][8*b +: 8] <= memWritedata[8*b +: 8];
         end else begin
            memReaddata <= ram[memAddress];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
   endtask

   function automatic cmd_t rdCmd(input logic [ADDR_W-1:0] a);
      cmd_t c;
      c = '0;
      c.rd = 1'b1;
      c.addr = a;
      c.be = '1;
      return c;
   endfunction

   function automatic cmd_t wrCmd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
      cmd_t c;
      c = '0;
      c.wr = 1'b1;
      c.addr = a;
      c.data = d;
      c.be = be;
      return c;
   endfunction

   // Drives one cycle of commands, checks the grant and RAM port at the falling
   // edge, and queues the expected return for a granted read.
   task automatic applyStimulus(input cmd_t c0, input cmd_t c1, input logic [1:0] expGrant,
                                input logic [DATA_W-1:0] expData);
      cmd_t g;
      sbEntry_t e;
      m0Read = c0.rd; m0Write = c0.wr; m0Address = c0.addr; m0Writedata = c0.data; m0Byteenable = c0.be;
      m1Read = c1.rd; m1Write = c1.wr; m1Address = c1.addr; m1Writedata = c1.data; m1Byteenable = c1.be;
      if (c0.rd && c0.wr) begin
         protoErrors++;
         $display("[TB] protocol error #%0d: m0 read and write both high, handled as a write", protoErrors);
      end
      if (c1.rd && c1.wr) begin
         protoErrors++;
         $display("[TB] protocol error #%0d: m1 read and write both high, handled as a write", protoErrors);
      end
      @(negedge clk);
      checkOutput("m0_waitrequest", 32'(m0Waitrequest), 32'(!expGrant[0]));
      checkOutput("m1_waitrequest", 32'(m1Waitrequest), 32'(!expGrant[1]));
      checkOutput("mem_chipselect", 32'(memChipselect), 32'(expGrant != 2'b00));
      checkOutput("mem_clken", 32'(memClken), 32'd1);
      if (expGrant != 2'b00) begin
         g = expGrant[1] ? c1 : c0;
         checkOutput("mem_address", 32'(memAddress), 32'(g.addr));
         checkOutput("mem_write", 32'(memWrite), 32'(g.wr));
         if (g.wr) begin
            checkOutput("mem_writedata", memWritedata, g.data);
            checkOutput("mem_byteenable", 32'(memByteenable), 32'(g.be));
         end else begin
            checkOutput("mem_byteenable", 32'(memByteenable), 32'hF);
            e.id   = expGrant[1] ? 1 : 0;
            e.data = expData;
            e.cyc  = cycleCount;
            sbQ.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Holds reset for n cycles; any read still in flight is cancelled by it.
   task automatic doReset(input int n);
      reset = 1'b1;
      m0Read = 1'b0; m0Write = 1'b0; m1Read = 1'b0; m1Write = 1'b0;
      sbQ.delete();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("reset m0_waitrequest", 32'(m0Waitrequest), 32'd1);
         checkOutput("reset m1_waitrequest", 32'(m1Waitrequest), 32'd1);
         checkOutput("reset mem_chipselect", 32'(memChipselect), 32'd0);
         checkOutput("reset mem_write", 32'(memWrite), 32'd0);
         checkOutput("reset mem_clken", 32'(memClken), 32'd0);
         checkOutput("reset readdatavalid", 32'({m1Readdatavalid, m0Readdatavalid}), 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   // Monitor: every read strobe must match the oldest queued read, one cycle on.
   always @(negedge clk) begin
      if (m0Readdatavalid || m1Readdatavalid) begin
         checkOutput("readdatavalid overlap", 32'(m0Readdatavalid & m1Readdatavalid), 32'd0);
         if (sbQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected readdatavalid: got {m1,m0}=%b, expected none (cycle %0d)",
                     {m1Readdatavalid, m0Readdatavalid}, cycleCount);
         end else begin
            sbEntry_t e;
            e = sbQ.pop_front();
            checkOutput("read return id", 32'(m1Readdatavalid), 32'(e.id));
            checkOutput("read latency", 32'(cycleCount - e.cyc), 32'd1);
            checkOutput("read data", m1Readdatavalid ? m1Readdata : m0Readdata, e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      m0Read = 1'b0; m0Write = 1'b0; m0Address = '0; m0Writedata = '0; m0Byteenable = '0;
      m1Read = 1'b0; m1Write = 1'b0; m1Address = '0; m1Writedata = '0; m1Byteenable = '0;
      @(posedge clk);
      #1;
      doReset(2);

      $display("[TB] single-master write then read");
      applyStimulus(wrCmd(14'h0010, 32'hDEADBEEF, 4'hF), IDLE, 2'b01, 32'h0);
      applyStimulus(rdCmd(14'h0010), IDLE, 2'b01, 32'hDEADBEEF);
      applyStimulus(IDLE, IDLE, 2'b00, 32'h0);
      applyStimulus(IDLE, wrCmd(14'h0011, 32'h0BADF00D, 4'hF), 2'b10, 32'h0);

      $display("[TB] contention fairness after reset");
      doReset(1);
      for (int i = 0; i < 8; i++)
         applyStimulus(rdCmd(14'h0010), rdCmd(14'h0011), (i % 2 == 0) ? 2'b01 : 2'b10,
                       (i % 2 == 0) ? 32'hDEADBEEF : 32'h0BADF00D);
      applyStimulus(IDLE, IDLE, 2'b00, 32'h0);

      $display("[TB] byte lanes");
      applyStimulus(wrCmd(14'h3FFF, 32'hFFFFFFFF, 4'hF), IDLE, 2'b01, 32'h0);
      applyStimulus(IDLE, wrCmd(14'h3FFF, 32'h00000012, 4'b0001), 2'b10, 32'h0);
      applyStimulus(IDLE, rdCmd(14'h3FFF), 2'b10, 32'hFFFFFF12);

      $display("[TB] back-to-back mixed traffic");
      applyStimulus(wrCmd(14'h0020, 32'h11111111, 4'hF), IDLE, 2'b01, 32'h0);
      applyStimulus(IDLE, rdCmd(14'h0020), 2'b10, 32'h11111111);
      applyStimulus(wrCmd(14'h0020, 32'h22222222, 4'hF), IDLE, 2'b01, 32'h0);
      applyStimulus(IDLE, rdCmd(14'h0020), 2'b10, 32'h22222222);

      $display("[TB] read and write both high");
      applyStimulus(wrCmd(14'h0030, 32'hA5A5A5A5, 4'hF) | cmd_t'({1'b1, {(1+ADDR_W+DATA_W+BE_W){1'b0}}}),
                    IDLE, 2'b01, 32'h0);
      applyStimulus(rdCmd(14'h0030), IDLE, 2'b01, 32'hA5A5A5A5);
      applyStimulus(IDLE, IDLE, 2'b00, 32'h0);

      $display("[TB] reset during an in-flight read");
      applyStimulus(IDLE, rdCmd(14'h0020), 2'b10, 32'h22222222);
      doReset(3);
      applyStimulus(rdCmd(14'h0010), rdCmd(14'h0011), 2'b01, 32'hDEADBEEF);
      applyStimulus(IDLE, rdCmd(14'h0011), 2'b10, 32'h0BADF00D);

      $display("[TB] idle cycles keep the last grant");
      applyStimulus(IDLE, rdCmd(14'h0011), 2'b10, 32'h0BADF00D);
      for (int i = 0; i < 5; i++) applyStimulus(IDLE, IDLE, 2'b00, 32'h0);
      applyStimulus(rdCmd(14'h0010), rdCmd(14'h0011), 2'b01, 32'hDEADBEEF);
      applyStimulus(IDLE, rdCmd(14'h0011), 2'b10, 32'h0BADF00D);

      applyStimulus(IDLE, IDLE, 2'b00, 32'h0);
      applyStimulus(IDLE, IDLE, 2'b00, 32'h0);
      checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
